// File: rtl/shift_serializer_hs_if.sv
// shift_serializer_hs_if
//   Handshake bundle between a wide word producer and a narrow beat consumer.
//   slave  : view taken by the serializer (accepts words, emits beats).
//   master : view taken by the environment (offers words, sinks beats).
//   Signals:
//     data_i  [FROM] word offered       valid_i  word valid       ready_o  word accepted
//     data_o  [TO]   current beat       valid_o  beat valid       ready_i  beat accepted
//     last_o         final beat of its word
interface shift_serializer_hs_if #(
   parameter int FROM = 64,
   parameter int TO   = 8
);
   logic [FROM-1:0] data_i;
   logic            valid_i;
   logic            ready_o;
   logic [TO-1:0]   data_o;
   logic            valid_o;
   logic            ready_i;
   logic            last_o;

   modport slave (
      input  data_i, valid_i, ready_i,
      output ready_o, data_o, valid_o, last_o
   );

   modport master (
      output data_i, valid_i, ready_i,
      input  ready_o, data_o, valid_o, last_o
   );
endinterface

// File: rtl/shift_serializer_hs.sv
// shift_serializer_hs
//   Splits FROM-bit words into FROM/TO beats of TO bits with valid/ready on
//   both sides. A shift stage holds the word being emitted; a one-word buffer
//   catches the next word so back-to-back words stream without a bubble.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     bus    shift_serializer_hs_if.slave (word in, beat out, last flag)
//   Parameters:
//     FROM       input word width (multiple of TO, at least 2 beats)
//     TO         output beat width
//     MSB_FIRST  1: most significant beat first, 0: least significant first
module shift_serializer_hs #(
   parameter int FROM      = 64,
   parameter int TO        = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   shift_serializer_hs_if.slave  bus
);

   localparam int BEATS = FROM / TO;
   localparam int CW    = (BEATS > 2) ? $clog2(BEATS) : 1;

   if ((FROM % TO) != 0 || (FROM / TO) < 2) begin : g_bad_params
      $error("shift_serializer_hs: FROM must be a multiple of TO with at least two beats");
   end

   typedef enum logic {EMPTY, SHIFT} state_t;

   state_t          state;
   logic [FROM-1:0] sh;        // word being emitted, current beat sits at the output end
   logic [CW-1:0]   cnt;       // index of the beat currently on data_o
   logic            last_q;
   logic [FROM-1:0] buf_q;
   logic            buf_v;

   logic            rdy;
   logic            in_hs;
   logic            out_hs;
   logic            done;
   logic [FROM-1:0] sh_adv;

   // Ready comes from registered state only, so valid_i/ready_i never
   // reach ready_o combinationally.
   assign rdy    = ~buf_v & ~reset;
   assign in_hs  = bus.valid_i & rdy;
   assign out_hs = (state == SHIFT) & bus.ready_i;
   assign done   = (cnt == CW'(BEATS - 1));

   // Next beat is moved to the output end of the word register, so data_o is
   // a fixed slice of a flop rather than a wide mux.
   always_comb begin
      sh_adv = sh;
      if (MSB_FIRST) sh_adv = {sh[FROM-TO-1:0], {TO{1'b0}}};
      else           sh_adv = {{TO{1'b0}}, sh[FROM-1:TO]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= EMPTY;
         sh     <= '0;
         cnt    <= '0;
         last_q <= 1'b0;
         buf_q  <= '0;
         buf_v  <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (in_hs) begin
                  sh     <= bus.data_i;
                  cnt    <= '0;
                  last_q <= 1'b0;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               if (out_hs && done) begin
                  // Buffered word is older than anything arriving now.
                  if (buf_v) begin
                     sh     <= buf_q;
                     cnt    <= '0;
                     last_q <= 1'b0;
                     buf_v  <= 1'b0;
                  end else if (in_hs) begin
                     sh     <= bus.data_i;
                     cnt    <= '0;
                     last_q <= 1'b0;
                  end else begin
                     sh     <= '0;
                     cnt    <= '0;
                     last_q <= 1'b0;
                     state  <= EMPTY;
                  end
               end else begin
                  if (out_hs) begin
                     sh     <= sh_adv;
                     cnt    <= cnt + CW'(1);
                     last_q <= (cnt == CW'(BEATS - 2));
                  end
                  // Shift stage still busy: park the incoming word.
                  if (in_hs) begin
                     buf_q <= bus.data_i;
                     buf_v <= 1'b1;
                  end
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   assign bus.ready_o = rdy;
   assign bus.valid_o = (state == SHIFT);
   assign bus.last_o  = last_q;
   assign bus.data_o  = MSB_FIRST ? sh[FROM-1 -: TO] : sh[TO-1:0];

endmodule
